// File: rtl/d_univ_shift_reg_if.sv
// Control, data and status bundle for d_univ_shift_reg.
// master drives the controls; slave is the register itself.
interface d_univ_shift_reg_if #(
   parameter int unsigned WIDTH = 8
);
   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sir;
   logic             sil;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qb;
   logic             sor;
   logic             sol;
   logic             busy;
   logic             done;

   modport master (
      output en, mode, d, sir, sil,
      input  q, qb, sor, sol, busy, done
   );

   modport slave (
      input  en, mode, d, sir, sil,
      output q, qb, sor, sol, busy, done
   );
endinterface

// File: rtl/d_univ_shift_reg.sv
// Universal WIDTH-bit register: hold, shift, rotate and parallel load,
// plus an auto-serialize mode that unloads a word LSB first under busy/done.
module d_univ_shift_reg #(
   parameter int unsigned WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   d_univ_shift_reg_if.slave bus
);
   localparam int unsigned CNTW = $clog2(WIDTH + 1);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHR  = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_LOAD = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_ROL  = 3'b101;
   localparam logic [2:0] MODE_SER  = 3'b110;

   typedef enum logic {
      IDLE = 1'b0,
      SER  = 1'b1
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic [WIDTH-1:0] qb_reg;
   logic [CNTW-1:0]  cnt, cnt_next;
   logic             done_reg, done_next;

   // State, data and status registers; qb tracks the complement of the next q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         q_reg    <= '0;
         qb_reg   <= '1;
         cnt      <= '0;
         done_reg <= 1'b0;
      end else begin
         state    <= state_next;
         q_reg    <= q_next;
         qb_reg   <= ~q_next;
         cnt      <= cnt_next;
         done_reg <= done_next;
      end
   end

   // Next-state and datapath selection; done defaults low so it pulses once.
   always_comb begin
      state_next = state;
      q_next     = q_reg;
      cnt_next   = cnt;
      done_next  = 1'b0;
      if (bus.en) begin
         unique case (state)
            IDLE: begin
               case (bus.mode)
                  MODE_SHR:  q_next = {bus.sir, q_reg[WIDTH-1:1]};
                  MODE_SHL:  q_next = {q_reg[WIDTH-2:0], bus.sil};
                  MODE_LOAD: q_next = bus.d;
                  MODE_ROR:  q_next = {q_reg[0], q_reg[WIDTH-1:1]};
                  MODE_ROL:  q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                  MODE_SER: begin
                     q_next     = bus.d;
                     cnt_next   = CNTW'(WIDTH);
                     state_next = SER;
                  end
                  MODE_HOLD: q_next = q_reg;
                  default:   q_next = q_reg;
               endcase
            end
            SER: begin
               // Counter is always >= 1 here, so the decrement cannot wrap.
               q_next   = {bus.sir, q_reg[WIDTH-1:1]};
               cnt_next = cnt - CNTW'(1);
               if (cnt == CNTW'(1)) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign bus.q    = q_reg;
   assign bus.qb   = qb_reg;
   assign bus.sor  = q_reg[0];
   assign bus.sol  = q_reg[WIDTH-1];
   assign bus.busy = (state == SER);
   assign bus.done = done_reg;
endmodule

// File: tb/tb_d_univ_shift_reg.sv
// Directed bench for d_univ_shift_reg at WIDTH=8 and the WIDTH=2 boundary.
module tb_d_univ_shift_reg;
   logic clk;
   logic rst;
   int   tests;
   int   fails;
   int   busy_cycles;
   logic [7:0] word;

   d_univ_shift_reg_if #(.WIDTH(8)) bus8 ();
   d_univ_shift_reg_if #(.WIDTH(2)) bus2 ();

   d_univ_shift_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   d_univ_shift_reg #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus8.en = 1'b0; bus8.mode = 3'b000; bus8.d = 8'h00; bus8.sir = 1'b0; bus8.sil = 1'b0;
      bus2.en = 1'b0; bus2.mode = 3'b000; bus2.d = 2'b00; bus2.sir = 1'b0; bus2.sil = 1'b0;
      tick();
      rst = 1'b0;

      // reset overrides a pending load
      bus8.en = 1'b1; bus8.mode = 3'b011; bus8.d = 8'hA5;
      tick();
      chk("load_a5", 32'(bus8.q), 32'h0000_00A5);
      rst = 1'b1; bus8.d = 8'hFF;
      tick();
      rst = 1'b0;
      chk("rst_q", 32'(bus8.q), 32'h0);
      chk("rst_qb", 32'(bus8.qb), 32'hFF);
      chk("rst_busy", 32'(bus8.busy), 32'h0);
      chk("rst_done", 32'(bus8.done), 32'h0);
      chk("rst_sor", 32'(bus8.sor), 32'h0);

      // shifts and rotates
      bus8.mode = 3'b011; bus8.d = 8'h81;
      tick();
      chk("load_81", 32'(bus8.q), 32'h81);
      chk("sol_81", 32'(bus8.sol), 32'h1);
      bus8.mode = 3'b100;
      tick();
      chk("ror", 32'(bus8.q), 32'hC0);
      chk("ror_qb", 32'(bus8.qb), 32'h3F);
      bus8.mode = 3'b101;
      tick();
      chk("rol", 32'(bus8.q), 32'h81);
      bus8.mode = 3'b010; bus8.sil = 1'b0;
      tick();
      chk("shl", 32'(bus8.q), 32'h02);
      chk("shl_qb", 32'(bus8.qb), 32'hFD);
      bus8.mode = 3'b001; bus8.sir = 1'b1;
      tick();
      chk("shr", 32'(bus8.q), 32'h81);
      chk("shr_qb", 32'(bus8.qb), 32'h7E);
      bus8.mode = 3'b000;
      tick();
      chk("hold", 32'(bus8.q), 32'h81);
      bus8.mode = 3'b111;
      tick();
      chk("reserved", 32'(bus8.q), 32'h81);
      bus8.en = 1'b0; bus8.mode = 3'b011; bus8.d = 8'h00;
      tick();
      chk("en_low", 32'(bus8.q), 32'h81);

      // auto-serialize, LSB first, MODE/D ignored while busy
      word = 8'b1011_0010;
      bus8.en = 1'b1; bus8.mode = 3'b110; bus8.d = word; bus8.sir = 1'b0;
      tick();
      bus8.mode = 3'b011; bus8.d = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("ser_busy%0d", k), 32'(bus8.busy), 32'h1);
         chk($sformatf("ser_sor%0d", k), 32'(bus8.sor), 32'(word[k]));
         chk($sformatf("ser_done%0d", k), 32'(bus8.done), 32'h0);
         tick();
      end
      chk("ser_end_busy", 32'(bus8.busy), 32'h0);
      chk("ser_end_done", 32'(bus8.done), 32'h1);
      chk("ser_end_q", 32'(bus8.q), 32'h00);
      bus8.mode = 3'b000;
      tick();
      chk("ser_done_clr", 32'(bus8.done), 32'h0);

      // stall for 3 cycles mid-word
      bus8.mode = 3'b110; bus8.d = word; bus8.sir = 1'b0;
      tick();
      busy_cycles = 0;
      bus8.mode = 3'b011; bus8.d = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         if (k == 3) begin
            bus8.en = 1'b0;
            for (int s = 0; s < 3; s++) begin
               chk($sformatf("stall_sor%0d", s), 32'(bus8.sor), 32'(word[3]));
               if (bus8.busy) busy_cycles++;
               tick();
            end
            bus8.en = 1'b1;
         end
         chk($sformatf("stall_bit%0d", k), 32'(bus8.sor), 32'(word[k]));
         chk($sformatf("stall_noload%0d", k), 32'(bus8.q == 8'hFF), 32'h0);
         if (bus8.busy) busy_cycles++;
         tick();
      end
      chk("stall_busy_len", 32'(busy_cycles), 32'd11);
      chk("stall_done", 32'(bus8.done), 32'h1);
      bus8.en = 1'b0;
      tick();
      chk("done_clr_en0", 32'(bus8.done), 32'h0);
      bus8.en = 1'b1; bus8.mode = 3'b000;

      // back-to-back words, then abort the second
      bus8.mode = 3'b110; bus8.d = word;
      tick();
      bus8.mode = 3'b000;
      for (int k = 0; k < 8; k++) tick();
      chk("b2b_done", 32'(bus8.done), 32'h1);
      bus8.mode = 3'b110; bus8.d = 8'h5A;
      tick();
      bus8.mode = 3'b000;
      chk("b2b_busy", 32'(bus8.busy), 32'h1);
      chk("b2b_q", 32'(bus8.q), 32'h5A);
      chk("b2b_sor0", 32'(bus8.sor), 32'h0);
      tick();
      chk("b2b_sor1", 32'(bus8.sor), 32'h1);
      tick();
      chk("b2b_sor2", 32'(bus8.sor), 32'h0);
      tick();
      chk("b2b_sor3", 32'(bus8.sor), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(bus8.busy), 32'h0);
      chk("abort_q", 32'(bus8.q), 32'h0);
      chk("abort_done", 32'(bus8.done), 32'h0);
      tick();
      chk("abort_nodone", 32'(bus8.done), 32'h0);

      // WIDTH=2 boundary
      bus2.en = 1'b1; bus2.mode = 3'b110; bus2.d = 2'b10; bus2.sir = 1'b1;
      tick();
      bus2.mode = 3'b000;
      chk("w2_busy0", 32'(bus2.busy), 32'h1);
      chk("w2_sor0", 32'(bus2.sor), 32'h0);
      tick();
      chk("w2_busy1", 32'(bus2.busy), 32'h1);
      chk("w2_sor1", 32'(bus2.sor), 32'h1);
      tick();
      chk("w2_busy_end", 32'(bus2.busy), 32'h0);
      chk("w2_done", 32'(bus2.done), 32'h1);
      chk("w2_q", 32'(bus2.q), 32'h3);
      chk("w2_qb", 32'(bus2.qb), 32'h0);
      tick();
      chk("w2_done_clr", 32'(bus2.done), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
